// File: rtl/correlator_cmd_pkg.sv
`default_nettype none
// correlator_cmd_pkg: command codes, nibble-byte layout and byte builders shared with the correlator receiver.
// Rev 1.0
package correlator_cmd_pkg;

  localparam logic [3:0] CMD_RESET                = 4'd0;
  localparam logic [3:0] CMD_SET_INTEGRATION_TIME = 4'd1;
  localparam logic [3:0] CMD_SET_SAMPLE_TIME      = 4'd2;
  localparam logic [3:0] CMD_SET_ACTIVE_LINE      = 4'd3;
  localparam logic [3:0] CMD_ENABLE_MODULES       = 4'd12;
  localparam logic [3:0] CMD_COMMIT               = 4'd13;

  localparam int NIB_DATA_LSB      = 4;
  localparam int NIB_CODE_LSB      = 0;
  localparam int NIBBLES_PER_FIELD = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FIELD_RST = 3'd1,
    ST_NIBBLE    = 3'd2,
    ST_ENABLE    = 3'd3,
    ST_COMMIT    = 3'd4,
    ST_FINISH    = 3'd5
  } cmd_state_t;

  function automatic logic [7:0] nibble_byte(input logic [3:0] nib, input logic [3:0] code);
    logic [7:0] b;
    b = 8'h00;
    b[NIB_DATA_LSB +: 4] = nib;
    b[NIB_CODE_LSB +: 4] = code;
    return b;
  endfunction

  // A field reset is a RESET command whose data nibble names the field.
  function automatic logic [7:0] field_reset_byte(input logic [3:0] code);
    return nibble_byte(code, CMD_RESET);
  endfunction

  function automatic logic [7:0] enable_byte(input logic [2:0] en);
    return nibble_byte({1'b0, en}, CMD_ENABLE_MODULES);
  endfunction

  function automatic logic [7:0] commit_byte();
    return nibble_byte(4'h0, CMD_COMMIT);
  endfunction

  function automatic logic [3:0] field_code(input logic [1:0] idx);
    return CMD_SET_INTEGRATION_TIME + {2'b00, idx};
  endfunction

  // Lowest set mask bit at or above 'from'; result is {found, index}.
  function automatic logic [2:0] next_field(input logic [2:0] mask, input logic [1:0] from);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      if (mask[i] && (2'(i) >= from)) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// uart_tx_byte: 8N1 byte serialiser with GAP_BITS idle-high bit times after the stop bit.
// Rev 1.0
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 217,
  parameter int GAP_BITS     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       TX
);

  localparam int              CNT_W          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST_CLK   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       FRAME_LAST_BIT = 4'(9 + GAP_BITS);

  logic             active;
  logic [CNT_W-1:0] clk_cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             bit_end;
  logic             frame_end;

  assign bit_end   = (clk_cnt == BIT_LAST_CLK);
  assign frame_end = active && bit_end && (bit_cnt == FRAME_LAST_BIT);
  // Ready in the final gap cycle lets the next start bit follow with no dead cycle.
  assign ready     = !active || frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      clk_cnt <= '0;
      bit_cnt <= 4'd0;
      shreg   <= 8'h00;
      TX      <= 1'b1;
    end else if (valid && ready) begin
      active  <= 1'b1;
      clk_cnt <= '0;
      bit_cnt <= 4'd0;
      shreg   <= data;
      TX      <= 1'b0;
    end else if (active) begin
      if (bit_end) begin
        clk_cnt <= '0;
        if (bit_cnt == FRAME_LAST_BIT) begin
          active  <= 1'b0;
          bit_cnt <= 4'd0;
          TX      <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt <= 4'd7) begin
            TX    <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
          end else begin
            TX <= 1'b1;
          end
        end
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/correlator_cmd_tx.sv
`default_nettype none
// correlator_cmd_tx: snapshots a correlator configuration on start and sends it as nibble commands over UART.
// Rev 1.0
module correlator_cmd_tx #(
  parameter int CLK_FREQUENCY = 50000000,
  parameter int BAUD_RATE     = 230400,
  parameter int GAP_BITS      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  field_mask,
  input  logic [63:0] integration_time,
  input  logic [63:0] sample_time,
  input  logic [63:0] active_line,
  input  logic [2:0]  enables,
  output logic        TX,
  output logic        busy,
  output logic        done
);
  import correlator_cmd_pkg::*;

  localparam int         CLKS_PER_BIT = CLK_FREQUENCY / BAUD_RATE;
  localparam logic [3:0] LAST_NIBBLE  = 4'(NIBBLES_PER_FIELD - 1);

  cmd_state_t  state, state_nx;
  logic [3:0]  nib_idx;
  logic [1:0]  fld;
  logic [2:0]  snap_mask;
  logic [2:0]  snap_en;
  logic [63:0] snap_int, snap_smp, snap_act;

  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        hs;
  logic [2:0]  first_fld;
  logic [2:0]  more_fld;
  logic [63:0] cur_val;
  logic [3:0]  cur_code;
  logic [3:0]  nib_sel;
  logic [3:0]  cur_nib;

  assign hs        = tx_valid & tx_ready;
  assign first_fld = next_field(field_mask, 2'd0);
  assign more_fld  = next_field(snap_mask, fld + 2'd1);
  assign cur_code  = field_code(fld);
  // The state names the byte in flight; the offered byte is the one that follows it.
  assign nib_sel   = (state == ST_NIBBLE) ? nib_idx + 4'd1 : 4'd0;
  assign cur_nib   = cur_val[{nib_sel, 2'b00} +: 4];

  always_comb begin
    case (fld)
      2'd0:    cur_val = snap_int;
      2'd1:    cur_val = snap_smp;
      default: cur_val = snap_act;
    endcase
  end

  always_comb begin
    state_nx = state;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state)
      ST_IDLE: begin
        if (start) begin
          tx_valid = 1'b1;
          if (first_fld[2]) begin
            tx_data  = field_reset_byte(field_code(first_fld[1:0]));
            state_nx = ST_FIELD_RST;
          end else begin
            tx_data  = enable_byte(enables);
            state_nx = ST_ENABLE;
          end
        end
      end
      ST_FIELD_RST: begin
        tx_valid = 1'b1;
        tx_data  = nibble_byte(cur_nib, cur_code);
        if (hs) state_nx = ST_NIBBLE;
      end
      ST_NIBBLE: begin
        tx_valid = 1'b1;
        if (nib_idx != LAST_NIBBLE) begin
          tx_data = nibble_byte(cur_nib, cur_code);
        end else if (more_fld[2]) begin
          tx_data = field_reset_byte(field_code(more_fld[1:0]));
          if (hs) state_nx = ST_FIELD_RST;
        end else begin
          tx_data = enable_byte(snap_en);
          if (hs) state_nx = ST_ENABLE;
        end
      end
      ST_ENABLE: begin
        tx_valid = 1'b1;
        tx_data  = commit_byte();
        if (hs) state_nx = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (tx_ready) state_nx = ST_FINISH;
      end
      ST_FINISH: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_idx   <= 4'd0;
      fld       <= 2'd0;
      snap_mask <= 3'b000;
      snap_en   <= 3'b000;
      snap_int  <= 64'd0;
      snap_smp  <= 64'd0;
      snap_act  <= 64'd0;
    end else if (state == ST_IDLE && start) begin
      nib_idx   <= 4'd0;
      fld       <= first_fld[1:0];
      snap_mask <= field_mask;
      snap_en   <= enables;
      snap_int  <= integration_time;
      snap_smp  <= sample_time;
      snap_act  <= active_line;
    end else if (hs && state == ST_NIBBLE) begin
      nib_idx <= nib_idx + 4'd1;
      if (nib_idx == LAST_NIBBLE && more_fld[2]) fld <= more_fld[1:0];
    end
  end

  assign busy = (state != ST_IDLE) && (state != ST_FINISH);
  assign done = (state == ST_FINISH);

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .GAP_BITS     (GAP_BITS)
  ) u_uart_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (tx_data),
    .valid (tx_valid),
    .ready (tx_ready),
    .TX    (TX)
  );

endmodule
`default_nettype wire

// File: tb/tb_correlator_cmd_tx.sv
`default_nettype none
// tb_correlator_cmd_tx: randomized configurations checked bit-by-bit against a byte-list reference model.
// Rev 1.0
module tb_correlator_cmd_tx;

  localparam int CPB        = 10;
  localparam int GAP        = 2;
  localparam int FRAME_BITS = 10 + GAP;
  localparam int BYTE_CYC   = FRAME_BITS * CPB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  field_mask;
  logic [63:0] integration_time, sample_time, active_line;
  logic [2:0]  enables;
  logic        tx, busy, done;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  correlator_cmd_tx #(
    .CLK_FREQUENCY (1000000),
    .BAUD_RATE     (100000),
    .GAP_BITS      (GAP)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .field_mask       (field_mask),
    .integration_time (integration_time),
    .sample_time      (sample_time),
    .active_line      (active_line),
    .enables          (enables),
    .TX               (tx),
    .busy             (busy),
    .done             (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected byte stream built directly from the command protocol rules.
  task automatic build_model(input logic [2:0] m, input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] c, input logic [2:0] e);
    logic [63:0] v[1:3];
    v[1] = a; v[2] = b; v[3] = c;
    exp_q.delete();
    for (int f = 1; f <= 3; f++) begin
      if (m[f-1]) begin
        exp_q.push_back(8'(f * 16));
        for (int k = 0; k < 16; k++)
          exp_q.push_back(8'(((v[f] >> (4 * k)) & 64'hF) * 16 + f));
      end
    end
    exp_q.push_back(8'(e) * 8'd16 + 8'd12);
    exp_q.push_back(8'h0D);
  endtask

  task automatic scramble();
    field_mask       = 3'($urandom);
    enables          = 3'($urandom);
    integration_time = {$urandom, $urandom};
    sample_time      = {$urandom, $urandom};
    active_line      = {$urandom, $urandom};
  endtask

  task automatic run_seq(input logic [2:0] m, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [2:0] e,
                         input bit disturb, input bit abort);
    logic [FRAME_BITS-1:0] frame_obs, frame_exp;
    bit stable, busy_ok;
    int n;
    build_model(m, a, b, c, e);
    n = exp_q.size();
    @(negedge clk);
    field_mask = m; integration_time = a; sample_time = b; active_line = c; enables = e;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("accept_tx_low", tx, 1'b0);
    check("accept_busy", busy, 1'b1);
    busy_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      frame_obs = '0;
      stable    = 1'b1;
      for (int cyc = 0; cyc < BYTE_CYC; cyc++) begin
        if (cyc % CPB == 0) frame_obs[cyc / CPB] = tx;
        else if (tx !== frame_obs[cyc / CPB]) stable = 1'b0;
        busy_ok &= (busy === 1'b1) && (done === 1'b0);
        if (disturb && i == 0 && cyc == 1) scramble();
        if (disturb && i == 1 && cyc == 5) begin scramble(); start = 1'b1; end
        if (disturb && i == 1 && cyc == 6) start = 1'b0;
        if (abort && i == 3 && cyc == 4 * CPB + 3) begin
          rst_n = 1'b0;
          #1;
          check("abort_tx", tx, 1'b1);
          check("abort_busy", busy, 1'b0);
          check("abort_done", done, 1'b0);
          @(negedge clk); @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        @(posedge clk); #1;
      end
      frame_exp = {{(FRAME_BITS - 9){1'b1}}, exp_q[i], 1'b0};
      check($sformatf("frame%0d", i), {stable, frame_obs}, {1'b1, frame_exp});
    end
    check("busy_whole_seq", busy_ok, 1'b1);
    check("done_pulse", done, 1'b1);
    check("busy_at_done", busy, 1'b0);
    scramble();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_one_cycle", done, 1'b0);
    check("start_at_done_ignored", {busy, tx}, 2'b01);
  endtask

  initial begin
    logic [63:0] va, vb, vc;
    logic [2:0]  ve;
    rst_n = 1'b0;
    start = 1'b0;
    field_mask = 3'b000; enables = 3'b000;
    integration_time = 64'd0; sample_time = 64'd0; active_line = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_tx", tx, 1'b1);

    run_seq(3'b000, 64'd0, 64'd0, 64'd0, 3'b101, 1'b0, 1'b0);
    run_seq(3'b010, {$urandom, $urandom}, 64'h0123456789ABCDEF, {$urandom, $urandom},
            3'($urandom), 1'b0, 1'b0);

    va = {$urandom, $urandom}; vb = {$urandom, $urandom}; vc = {$urandom, $urandom};
    ve = 3'($urandom);
    run_seq(3'b111, va, vb, vc, ve, 1'b0, 1'b0);
    run_seq(3'b111, va, vb, vc, ve, 1'b1, 1'b0);
    run_seq(3'b111, va, vb, vc, ve, 1'b0, 1'b1);
    run_seq(3'b111, va, vb, vc, ve, 1'b0, 1'b0);

    for (int r = 0; r < 3; r++)
      run_seq(3'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              3'($urandom), 1'($urandom), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
